// File: rtl/i2c_pkg.sv
// Shared types and encodings for the single-byte I2C master controller.
// bus_drive() maps (state, quarter phase, current bit) to the open-drain pull-downs.
package i2c_pkg;

   typedef enum logic [3:0] {
      IDLE,
      START,
      ADDR,
      ADDR_ACK,
      WRITE,
      WRITE_ACK,
      READ,
      READ_NACK,
      STOP,
      DONE
   } i2c_mst_state_e;

   localparam logic RW_WRITE = 1'b0;
   localparam logic RW_READ  = 1'b1;
   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

   typedef struct packed {
      logic scl_oe;
      logic sda_oe;
   } i2c_drive_t;

   function automatic i2c_drive_t bus_drive(input i2c_mst_state_e st,
                                            input logic [1:0]     ph,
                                            input logic           tx_bit);
      i2c_drive_t d;
      d.scl_oe = 1'b0;
      d.sda_oe = 1'b0;
      case (st)
         START: begin
            d.sda_oe = (ph != 2'd0);
            d.scl_oe = (ph == 2'd3);
         end
         ADDR, WRITE: begin
            d.scl_oe = (ph == 2'd0) || (ph == 2'd3);
            d.sda_oe = ~tx_bit;
         end
         // Receive phases: SCL keeps toggling, SDA is left to the slave.
         ADDR_ACK, WRITE_ACK, READ, READ_NACK: begin
            d.scl_oe = (ph == 2'd0) || (ph == 2'd3);
         end
         STOP: begin
            d.scl_oe = (ph == 2'd0);
            d.sda_oe = (ph == 2'd0) || (ph == 2'd1);
         end
         default: ;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-period tick generator: tick every CLK_DIV enabled clocks, with a
// 2-bit phase counter that advances on each tick.
module i2c_tick_gen #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en_i,
   input  logic       clr_i,
   output logic       tick_o,
   output logic [1:0] q_o
);

   localparam logic [7:0] CNT_MAX = 8'(CLK_DIV - 1);

   logic [7:0] cnt_q;
   logic [1:0] q_q;

   assign tick_o = en_i && (cnt_q == CNT_MAX);
   assign q_o    = q_q;

   always_ff @(posedge clk) begin
      if (reset || clr_i) begin
         cnt_q <= '0;
         q_q   <= '0;
      end else if (en_i) begin
         if (tick_o) begin
            cnt_q <= '0;
            q_q   <= q_q + 2'd1;
         end else begin
            cnt_q <= cnt_q + 8'd1;
         end
      end
   end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, address+R/W, ACK, one data byte, ACK/NACK, STOP.
// Bus pins are open-drain enables; SCL is never sampled (no clock stretching).
module i2c_master_ctrl
   import i2c_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [6:0] cmd_addr,
   input  logic       cmd_rw,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       rsp_nack,
   output logic       busy,
   output logic       i2c_scl_oe,
   output logic       i2c_sda_oe,
   input  logic       i2c_sda_in
);

   i2c_mst_state_e state_q;
   logic [6:0]     addr_q;
   logic           rw_q;
   logic [7:0]     wdata_q;
   logic [2:0]     bit_cnt_q;
   logic           cmd_ready_q;
   logic           busy_q;
   logic           rsp_valid_q;
   logic           rsp_nack_q;
   logic [7:0]     rsp_rdata_q;
   i2c_drive_t     drive_q;
   i2c_drive_t     drive_d;

   logic       tick;
   logic       tick_en;
   logic [1:0] q;
   logic [7:0] tx_byte;
   logic       tx_bit;
   logic       sample;
   logic       bit_end;

   assign tick_en = (state_q != IDLE) && (state_q != DONE);

   i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
      .clk    (clk),
      .reset  (reset),
      .en_i   (tick_en),
      .clr_i  (!tick_en),
      .tick_o (tick),
      .q_o    (q)
   );

   assign tx_byte = (state_q == WRITE) ? wdata_q : {addr_q, rw_q};
   assign tx_bit  = tx_byte[3'd7 - bit_cnt_q];
   assign sample  = tick && (q == 2'd2);
   assign bit_end = tick && (q == 2'd3);
   assign drive_d = bus_drive(state_q, q, tx_bit);

   // NOTE: all state, including the pin drivers, updates with non-blocking
   // assignments in one clocked block so the pins are glitch-free flop outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         rw_q        <= RW_WRITE;
         wdata_q     <= '0;
         bit_cnt_q   <= '0;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_nack_q  <= 1'b0;
         rsp_rdata_q <= '0;
         drive_q     <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         drive_q     <= drive_d;
         case (state_q)
            IDLE: begin
               if (cmd_valid && cmd_ready_q) begin
                  addr_q      <= cmd_addr;
                  rw_q        <= cmd_rw;
                  wdata_q     <= cmd_wdata;
                  rsp_rdata_q <= '0;
                  rsp_nack_q  <= 1'b0;
                  bit_cnt_q   <= '0;
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  state_q     <= START;
               end
            end
            START: if (bit_end) state_q <= ADDR;
            ADDR, WRITE: begin
               if (bit_end) begin
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) state_q <= (state_q == ADDR) ? ADDR_ACK : WRITE_ACK;
               end
            end
            ADDR_ACK: begin
               if (sample) rsp_nack_q <= (i2c_sda_in != I2C_ACK);
               if (bit_end) begin
                  if (rsp_nack_q == I2C_NACK) state_q <= STOP;
                  else if (rw_q == RW_READ)   state_q <= READ;
                  else                        state_q <= WRITE;
               end
            end
            WRITE_ACK: begin
               if (sample)  rsp_nack_q <= (i2c_sda_in != I2C_ACK);
               if (bit_end) state_q    <= STOP;
            end
            READ: begin
               if (sample) rsp_rdata_q <= {rsp_rdata_q[6:0], i2c_sda_in};
               if (bit_end) begin
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) state_q <= READ_NACK;
               end
            end
            READ_NACK: if (bit_end) state_q <= STOP;
            STOP:      if (bit_end) state_q <= DONE;
            DONE: begin
               rsp_valid_q <= 1'b1;
               cmd_ready_q <= 1'b1;
               busy_q      <= 1'b0;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cmd_ready  = cmd_ready_q;
   assign busy       = busy_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_rdata  = rsp_rdata_q;
   assign rsp_nack   = rsp_nack_q;
   assign i2c_scl_oe = drive_q.scl_oe;
   assign i2c_sda_oe = drive_q.sda_oe;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Scoreboard bench for i2c_master_ctrl: a behavioural I2C slave on the bus,
// expected responses and bus frames queued at issue time, checked by monitors.
module tb_i2c_master_ctrl;

   localparam int          CLK_DIV   = 4;
   localparam int          LAT_FULL  = 80 * CLK_DIV + 2;
   localparam int          LAT_NACK  = 44 * CLK_DIV + 2;
   localparam logic [6:0]  SLV_ADDR  = 7'h54;
   localparam logic [7:0]  SLV_RDATA = 8'hA5;

   typedef struct {
      logic [7:0] rdata;
      logic       nack;
      int         lat;
   } rsp_exp_t;

   typedef struct {
      logic [7:0] addr_byte;
      int         nbytes;
      logic [7:0] data_byte;
      logic       last_ack;
   } frame_exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       cmd_valid = 1'b0;
   logic [6:0] cmd_addr = '0;
   logic       cmd_rw = 1'b0;
   logic [7:0] cmd_wdata = '0;
   logic       cmd_ready;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_nack;
   logic       busy;
   logic       i2c_scl_oe;
   logic       i2c_sda_oe;
   logic       s_pull = 1'b0;

   wire scl = ~i2c_scl_oe;
   wire sda = ~(i2c_sda_oe | s_pull);

   i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_addr   (cmd_addr),
      .cmd_rw     (cmd_rw),
      .cmd_wdata  (cmd_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_nack   (rsp_nack),
      .busy       (busy),
      .i2c_scl_oe (i2c_scl_oe),
      .i2c_sda_oe (i2c_sda_oe),
      .i2c_sda_in (sda)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;
   int n_rsp   = 0;
   int n_start = 0;
   int n_stop  = 0;

   rsp_exp_t   exp_rsp[$];
   frame_exp_t exp_frm[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected response and bus frame for a command against the bus slave model.
   task automatic expect_txn(input logic [6:0] a, input logic rw, input logic [7:0] wd);
      rsp_exp_t   r;
      frame_exp_t f;
      logic       acked;
      acked       = (a == SLV_ADDR);
      r.nack      = !acked;
      r.rdata     = (acked && rw) ? SLV_RDATA : 8'h00;
      r.lat       = acked ? LAT_FULL : LAT_NACK;
      f.addr_byte = {a, rw};
      f.nbytes    = acked ? 2 : 1;
      f.data_byte = rw ? SLV_RDATA : wd;
      f.last_ack  = acked ? rw : 1'b1;
      exp_rsp.push_back(r);
      exp_frm.push_back(f);
   endtask

   task automatic issue(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                        input bit hold, output int acc);
      @(posedge clk); #1;
      cmd_addr  = a;
      cmd_rw    = rw;
      cmd_wdata = wd;
      cmd_valid = 1'b1;
      acc = -1;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (cmd_ready === 1'b1) begin
            acc = cyc;
            break;
         end
      end
      @(posedge clk); #1;
      if (!hold) cmd_valid = 1'b0;
      check("accept_seen", (acc >= 0), 1'b1);
      check("ready_drop", cmd_ready, 1'b0);
      check("busy_rise", busy, 1'b1);
   endtask

   task automatic wait_rsp(input int n);
      for (int i = 0; i < 2000 && n_rsp < n; i++) @(negedge clk);
      check("rsp_count", n_rsp, n);
   endtask

   // Response monitor.
   int acc_cyc = 0;
   rsp_exp_t cur_r;
   always @(negedge clk) begin
      if (!reset) begin
         if (rsp_valid === 1'b1) begin
            n_rsp++;
            if (exp_rsp.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL rsp_unexpected: rsp_valid=1 with no outstanding command (cycle %0d)", cyc);
            end else begin
               cur_r = exp_rsp.pop_front();
               check("rsp_rdata", rsp_rdata, cur_r.rdata);
               check("rsp_nack", rsp_nack, cur_r.nack);
               check("rsp_latency", cyc - acc_cyc, cur_r.lat);
            end
         end
         if (cmd_valid && cmd_ready === 1'b1) acc_cyc = cyc;
      end
   end

   // Bus slave model and frame monitor.
   logic       scl_p = 1'b1;
   logic       sda_p = 1'b1;
   bit         in_frame = 1'b0;
   bit         rd_mode = 1'b0;
   int         bit_idx = 0;
   int         byte_num = 0;
   logic [7:0] shreg = '0;
   logic [7:0] fr_addr = '0;
   logic [7:0] fr_data = '0;
   logic       fr_ack = 1'b0;
   frame_exp_t cur_f;

   always @(negedge clk) begin
      if (scl === 1'b1 && scl_p === 1'b1 && sda_p === 1'b1 && sda === 1'b0) begin
         n_start++;
         in_frame = 1'b1;
         rd_mode  = 1'b0;
         bit_idx  = 0;
         byte_num = 0;
         s_pull   = 1'b0;
      end else if (scl === 1'b1 && scl_p === 1'b1 && sda_p === 1'b0 && sda === 1'b1) begin
         n_stop++;
         in_frame = 1'b0;
         s_pull   = 1'b0;
         if (exp_frm.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL frame_unexpected: STOP with no expected frame (cycle %0d)", cyc);
         end else begin
            cur_f = exp_frm.pop_front();
            check("frame_addr", fr_addr, cur_f.addr_byte);
            check("frame_bytes", byte_num, cur_f.nbytes);
            if (cur_f.nbytes == 2) check("frame_data", fr_data, cur_f.data_byte);
            check("frame_last_ack", fr_ack, cur_f.last_ack);
         end
      end else if (in_frame && scl === 1'b1 && scl_p === 1'b0) begin
         if (bit_idx < 8) begin
            shreg = {shreg[6:0], sda};
            bit_idx++;
         end else begin
            if (byte_num == 0) fr_addr = shreg;
            else               fr_data = shreg;
            fr_ack  = sda;
            bit_idx = 9;
         end
      end else if (in_frame && scl === 1'b0 && scl_p === 1'b1) begin
         if (bit_idx == 9) begin
            byte_num++;
            bit_idx = 0;
         end
         if (rd_mode && byte_num == 1 && bit_idx < 8) begin
            s_pull = ~SLV_RDATA[7 - bit_idx];
         end else if (bit_idx == 8 && byte_num == 0 && shreg[7:1] == SLV_ADDR) begin
            s_pull  = 1'b1;
            rd_mode = shreg[0];
         end else if (bit_idx == 8 && byte_num == 1 && !rd_mode) begin
            s_pull = 1'b1;
         end else begin
            s_pull = 1'b0;
         end
      end
      scl_p = scl;
      sda_p = sda;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a1;
      int a2;
      int nr;

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check("rst_cmd_ready", cmd_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rsp_rdata", rsp_rdata, 8'h00);
      check("rst_rsp_nack", rsp_nack, 1'b0);
      check("rst_scl_oe", i2c_scl_oe, 1'b0);
      check("rst_sda_oe", i2c_sda_oe, 1'b0);

      // Write with ACK: address byte 0xA8, data 0xCC.
      expect_txn(7'h54, i2c_pkg::RW_WRITE, 8'hCC);
      issue(7'h54, i2c_pkg::RW_WRITE, 8'hCC, 1'b0, a1);
      wait_rsp(1);

      // Address NACK: nobody answers 0x2A.
      expect_txn(7'h2A, i2c_pkg::RW_WRITE, 8'h3C);
      issue(7'h2A, i2c_pkg::RW_WRITE, 8'h3C, 1'b0, a1);
      wait_rsp(2);

      // Read 0xA5; the sticky NACK from before must clear at accept.
      expect_txn(7'h54, i2c_pkg::RW_READ, 8'h00);
      issue(7'h54, i2c_pkg::RW_READ, 8'h00, 1'b0, a1);
      check("nack_clear_on_accept", rsp_nack, 1'b0);
      wait_rsp(3);

      // Back-to-back with cmd_valid held high.
      expect_txn(7'h54, i2c_pkg::RW_WRITE, 8'h11);
      expect_txn(7'h54, i2c_pkg::RW_WRITE, 8'h22);
      issue(7'h54, i2c_pkg::RW_WRITE, 8'h11, 1'b1, a1);
      issue(7'h54, i2c_pkg::RW_WRITE, 8'h22, 1'b0, a2);
      check("b2b_accept_cycle", a2 - a1, LAT_FULL);
      wait_rsp(5);

      // Command pulse while busy must be ignored.
      expect_txn(7'h54, i2c_pkg::RW_WRITE, 8'h96);
      issue(7'h54, i2c_pkg::RW_WRITE, 8'h96, 1'b0, a1);
      repeat (100) @(posedge clk);
      #1;
      cmd_addr  = 7'h7F;
      cmd_wdata = 8'hFF;
      cmd_valid = 1'b1;
      @(negedge clk);
      check("busy_ignore_ready", cmd_ready, 1'b0);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      wait_rsp(6);

      // Reset during q0 of the 4th address bit.
      issue(7'h54, i2c_pkg::RW_WRITE, 8'h33, 1'b0, a1);
      repeat (66) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      check("midrst_scl_oe", i2c_scl_oe, 1'b0);
      check("midrst_sda_oe", i2c_sda_oe, 1'b0);
      check("midrst_cmd_ready", cmd_ready, 1'b1);
      check("midrst_busy", busy, 1'b0);
      check("midrst_rsp_valid", rsp_valid, 1'b0);
      nr = n_rsp;
      repeat (400) @(posedge clk);
      check("midrst_no_rsp", n_rsp, nr);

      // Normal operation after the aborted transaction.
      expect_txn(7'h54, i2c_pkg::RW_WRITE, 8'h5A);
      issue(7'h54, i2c_pkg::RW_WRITE, 8'h5A, 1'b0, a1);
      wait_rsp(7);

      repeat (20) @(posedge clk);
      check("rsp_queue_drained", exp_rsp.size(), 0);
      check("frame_queue_drained", exp_frm.size(), 0);
      check("start_count", n_start, 8);
      check("stop_count", n_stop, 7);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
